// File: rtl/fib_seq_gen.sv
// fib_seq_gen: parametrised Fibonacci-class sequence generator.
//   Each term is the sum of the two terms before it. Loadable seeds make one
//   block serve Fibonacci, Lucas and arbitrary second-order recurrences.
//   Terms leave on a valid/ready handshake together with a 0-based index.
//   An optional term limit ends the run. On overflow the block either stops
//   or wraps modulo 2^WIDTH. Single clock domain; all outputs are registered.
//
// Parameters:
//   WIDTH     term width in bits (>= 2)
//   IDX_W     term index counter width
//   MAX_TERMS number of terms emitted before DONE; 0 = unlimited
//   OVF_MODE  0 = stop before the first overflowed term, 1 = wrap and continue
//
// Ports:
//   clock      in   system clock, rising edge
//   reset      in   asynchronous active-low reset
//   start      in   pulse: load seeds, clear index/flags, enter RUN
//   seed_a     in   term 0, sampled on start
//   seed_b     in   term 1, sampled on start
//   en         in   advance permission; 0 pauses without losing position
//   out_ready  in   consumer ready
//   out_valid  out  out_data/out_index hold a term
//   out_data   out  current term
//   out_index  out  index of the current term
//   overflow   out  sticky: a sum exceeded 2^WIDTH-1
//   done       out  sequence finished (term limit or stop-on-overflow)
//   busy       out  generator is in RUN
module fib_seq_gen #(
   parameter int unsigned WIDTH     = 16,
   parameter int unsigned IDX_W     = 8,
   parameter int unsigned MAX_TERMS = 0,
   parameter int unsigned OVF_MODE  = 0
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             start,
   input  logic [WIDTH-1:0] seed_a,
   input  logic [WIDTH-1:0] seed_b,
   input  logic             en,
   input  logic             out_ready,
   output logic             out_valid,
   output logic [WIDTH-1:0] out_data,
   output logic [IDX_W-1:0] out_index,
   output logic             overflow,
   output logic             done,
   output logic             busy
);

   localparam int unsigned SUM_W = WIDTH + 1;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_RUN  = 2'd1,
      S_DONE = 2'd2
   } state_e;

   state_e             state_q, state_d;
   // data_q is the term on display (the "current" term); nxt_q is the one after.
   logic [WIDTH-1:0]   data_q,  data_d;
   logic [WIDTH-1:0]   nxt_q,   nxt_d;
   // Carry out of the sum that produced nxt_q: nxt_q is not representable.
   logic               nxt_cy_q, nxt_cy_d;
   logic [IDX_W-1:0]   idx_q,   idx_d;
   logic               valid_q, valid_d;
   logic               ovf_q,   ovf_d;
   logic               done_q,  done_d;
   logic               busy_q,  busy_d;

   logic [SUM_W-1:0]   sum_c;
   logic               xfer_c;
   logic               last_c;
   logic               stop_c;

   // Next-term sum at WIDTH+1 bits so the carry is kept for overflow detection.
   assign sum_c  = {1'b0, data_q} + {1'b0, nxt_q};
   assign xfer_c = valid_q & out_ready;

   // Term limit reached when the term being handed over has index MAX_TERMS-1.
   assign last_c = (MAX_TERMS != 0) && (idx_q == IDX_W'(MAX_TERMS - 1));

   // In stop mode, the term that would be shown next is a carried sum.
   assign stop_c = (OVF_MODE == 0) && nxt_cy_q;

   // State and datapath registers.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state_q  <= S_IDLE;
         data_q   <= '0;
         nxt_q    <= '0;
         nxt_cy_q <= 1'b0;
         idx_q    <= '0;
         valid_q  <= 1'b0;
         ovf_q    <= 1'b0;
         done_q   <= 1'b0;
         busy_q   <= 1'b0;
      end else begin
         state_q  <= state_d;
         data_q   <= data_d;
         nxt_q    <= nxt_d;
         nxt_cy_q <= nxt_cy_d;
         idx_q    <= idx_d;
         valid_q  <= valid_d;
         ovf_q    <= ovf_d;
         done_q   <= done_d;
         busy_q   <= busy_d;
      end
   end

   // Next-state and datapath update.
   always_comb begin
      state_d  = state_q;
      data_d   = data_q;
      nxt_d    = nxt_q;
      nxt_cy_d = nxt_cy_q;
      idx_d    = idx_q;
      valid_d  = valid_q;
      ovf_d    = ovf_q;
      done_d   = done_q;
      busy_d   = busy_q;

      if (start) begin
         // Reload wins over any transfer or overflow in the same cycle.
         state_d  = S_RUN;
         data_d   = seed_a;
         nxt_d    = seed_b;
         nxt_cy_d = 1'b0;
         idx_d    = '0;
         valid_d  = 1'b0;
         ovf_d    = 1'b0;
         done_d   = 1'b0;
         busy_d   = 1'b1;
      end else begin
         unique case (state_q)
            S_IDLE: begin
               valid_d = 1'b0;
            end

            S_RUN: begin
               valid_d = en;
               if (xfer_c) begin
                  ovf_d = ovf_q | sum_c[WIDTH];
                  if (last_c || stop_c) begin
                     // Keep the last handed-over term on display.
                     state_d = S_DONE;
                     valid_d = 1'b0;
                     done_d  = 1'b1;
                     busy_d  = 1'b0;
                  end else begin
                     data_d   = nxt_q;
                     nxt_d    = sum_c[WIDTH-1:0];
                     nxt_cy_d = sum_c[WIDTH];
                     idx_d    = idx_q + IDX_W'(1);
                  end
               end
            end

            S_DONE: begin
               valid_d = 1'b0;
            end

            default: begin
               state_d = S_IDLE;
               valid_d = 1'b0;
               busy_d  = 1'b0;
            end
         endcase
      end
   end

   assign out_valid = valid_q;
   assign out_data  = data_q;
   assign out_index = idx_q;
   assign overflow  = ovf_q;
   assign done      = done_q;
   assign busy      = busy_q;

endmodule

// File: tb/tb_fib_seq_gen.sv
// Directed bench for fib_seq_gen: three instances share one stimulus stream.
//   dut 0: stop on overflow, unlimited terms
//   dut 1: wrap on overflow, unlimited terms
//   dut 2: stop on overflow, MAX_TERMS = 10
module tb_fib_seq_gen;

   logic        clock;
   logic        reset;
   logic        start;
   logic [15:0] seed_a;
   logic [15:0] seed_b;
   logic        en;
   logic        out_ready;

   logic [2:0]  v;
   logic [2:0]  ovf;
   logic [2:0]  dn;
   logic [2:0]  bz;
   logic [15:0] d  [3];
   logic [7:0]  ix [3];

   int vectors;
   int miscompares;

   fib_seq_gen #(.WIDTH(16), .IDX_W(8), .MAX_TERMS(0), .OVF_MODE(0)) u_dut0 (
      .clock(clock), .reset(reset), .start(start), .seed_a(seed_a), .seed_b(seed_b),
      .en(en), .out_ready(out_ready), .out_valid(v[0]), .out_data(d[0]),
      .out_index(ix[0]), .overflow(ovf[0]), .done(dn[0]), .busy(bz[0]));

   fib_seq_gen #(.WIDTH(16), .IDX_W(8), .MAX_TERMS(0), .OVF_MODE(1)) u_dut1 (
      .clock(clock), .reset(reset), .start(start), .seed_a(seed_a), .seed_b(seed_b),
      .en(en), .out_ready(out_ready), .out_valid(v[1]), .out_data(d[1]),
      .out_index(ix[1]), .overflow(ovf[1]), .done(dn[1]), .busy(bz[1]));

   fib_seq_gen #(.WIDTH(16), .IDX_W(8), .MAX_TERMS(10), .OVF_MODE(0)) u_dut2 (
      .clock(clock), .reset(reset), .start(start), .seed_a(seed_a), .seed_b(seed_b),
      .en(en), .out_ready(out_ready), .out_valid(v[2]), .out_data(d[2]),
      .out_index(ix[2]), .overflow(ovf[2]), .done(dn[2]), .busy(bz[2]));

   initial clock = 1'b0;
   always #5 clock = ~clock;

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp)
      else begin
         miscompares++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   initial begin
      int unsigned fib8   [8];
      int unsigned lucas7 [7];
      int unsigned rst5   [4];
      logic        rdy_pat [13];
      logic        en_pat  [13];
      int unsigned acc    [16];
      int unsigned a;
      int unsigned b;
      int unsigned t;
      int          n;

      fib8    = '{0, 1, 1, 2, 3, 5, 8, 13};
      lucas7  = '{2, 1, 3, 4, 7, 11, 18};
      rst5    = '{5, 5, 10, 15};
      rdy_pat = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1};
      en_pat  = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
      vectors     = 0;
      miscompares = 0;

      reset = 1'b0; start = 1'b0; seed_a = '0; seed_b = '0; en = 1'b0; out_ready = 1'b0;

      // Reset state
      #12;
      for (int i = 0; i < 3; i++) begin
         chk($sformatf("rst_valid%0d", i), 32'(v[i]),  0);
         chk($sformatf("rst_data%0d",  i), 32'(d[i]),  0);
         chk($sformatf("rst_index%0d", i), 32'(ix[i]), 0);
         chk($sformatf("rst_ovf%0d",   i), 32'(ovf[i]), 0);
         chk($sformatf("rst_done%0d",  i), 32'(dn[i]), 0);
         chk($sformatf("rst_busy%0d",  i), 32'(bz[i]), 0);
      end
      reset = 1'b1;
      tick();

      // Fibonacci 0/1 at full throughput
      seed_a = 16'd0; seed_b = 16'd1; en = 1'b1; out_ready = 1'b1; start = 1'b1;
      tick();
      start = 1'b0;
      chk("t1_latency_valid", 32'(v[0]), 0);
      chk("t1_busy", 32'(bz[0]), 1);
      tick();
      for (int k = 0; k < 8; k++) begin
         chk($sformatf("t1_valid[%0d]", k), 32'(v[0]),  1);
         chk($sformatf("t1_data[%0d]",  k), 32'(d[0]),  fib8[k]);
         chk($sformatf("t1_index[%0d]", k), 32'(ix[0]), 32'(k));
         tick();
      end

      // Lucas 2/1, then restart with 5/5 mid-stream
      seed_a = 16'd2; seed_b = 16'd1; start = 1'b1;
      tick();
      start = 1'b0;
      tick();
      for (int k = 0; k < 7; k++) begin
         chk($sformatf("t2_data[%0d]",  k), 32'(d[0]),  lucas7[k]);
         chk($sformatf("t2_index[%0d]", k), 32'(ix[0]), 32'(k));
         if (k < 6) tick();
      end
      seed_a = 16'd5; seed_b = 16'd5; start = 1'b1;
      tick();
      start = 1'b0;
      chk("t2_restart_valid", 32'(v[0]),  0);
      chk("t2_restart_index", 32'(ix[0]), 0);
      tick();
      for (int k = 0; k < 4; k++) begin
         chk($sformatf("t2b_data[%0d]",  k), 32'(d[0]),  rst5[k]);
         chk($sformatf("t2b_index[%0d]", k), 32'(ix[0]), 32'(k));
         tick();
      end

      // Free run 0/1: overflow stop (dut0), wrap (dut1), term limit 10 (dut2)
      seed_a = 16'd0; seed_b = 16'd1; start = 1'b1;
      tick();
      start = 1'b0;
      tick();
      a = 0; b = 1;
      for (int k = 0; k <= 24; k++) begin
         chk($sformatf("t3_d0[%0d]", k), 32'(d[0]),  a);
         chk($sformatf("t3_i0[%0d]", k), 32'(ix[0]), 32'(k));
         chk($sformatf("t3_v0[%0d]", k), 32'(v[0]),  1);
         chk($sformatf("t3_d1[%0d]", k), 32'(d[1]),  a);
         if (k == 10) begin
            chk("t3_lim_valid", 32'(v[2]),  0);
            chk("t3_lim_done",  32'(dn[2]), 1);
            chk("t3_lim_busy",  32'(bz[2]), 0);
            chk("t3_lim_data",  32'(d[2]),  34);
            chk("t3_lim_index", 32'(ix[2]), 9);
         end
         if (k == 23) begin
            chk("t3_ovf0_pre", 32'(ovf[0]), 0);
            chk("t3_ovf1_pre", 32'(ovf[1]), 0);
         end
         if (k == 24) begin
            chk("t3_ovf0_set", 32'(ovf[0]), 1);
            chk("t3_ovf1_set", 32'(ovf[1]), 1);
            chk("t3_done0_pre", 32'(dn[0]), 0);
         end
         t = a + b; a = b; b = t;
         tick();
      end
      chk("t3_stop_valid", 32'(v[0]),   0);
      chk("t3_stop_done",  32'(dn[0]),  1);
      chk("t3_stop_ovf",   32'(ovf[0]), 1);
      chk("t3_stop_data",  32'(d[0]),   46368);
      chk("t3_stop_index", 32'(ix[0]),  24);
      chk("t3_stop_busy",  32'(bz[0]),  0);
      chk("t3_wrap_valid", 32'(v[1]),   1);
      chk("t3_wrap_data",  32'(d[1]),   9489);
      chk("t3_wrap_index", 32'(ix[1]),  25);
      tick();
      chk("t3_stop_hold_valid", 32'(v[0]),   0);
      chk("t3_stop_hold_data",  32'(d[0]),   46368);
      chk("t3_wrap_next_data",  32'(d[1]),   55857);
      chk("t3_wrap_next_index", 32'(ix[1]),  26);
      chk("t3_wrap_ovf_sticky", 32'(ovf[1]), 1);
      chk("t3_wrap_done",       32'(dn[1]),  0);

      // Backpressure (ready low at index 4) and pause (en low at index 6)
      seed_a = 16'd0; seed_b = 16'd1; en = 1'b1; out_ready = 1'b1; start = 1'b1;
      tick();
      start = 1'b0;
      tick();
      n = 0;
      for (int c = 0; c < 13; c++) begin
         out_ready = rdy_pat[c];
         en        = en_pat[c];
         if (c >= 5 && c <= 7) begin
            chk($sformatf("t4_hold_valid[%0d]", c), 32'(v[0]),  1);
            chk($sformatf("t4_hold_data[%0d]",  c), 32'(d[0]),  3);
            chk($sformatf("t4_hold_index[%0d]", c), 32'(ix[0]), 4);
         end
         if (c == 10 || c == 11)
            chk($sformatf("t4_pause_valid[%0d]", c), 32'(v[0]), 0);
         if (v[0] && out_ready && n < 16) begin
            acc[n] = 32'(d[0]);
            n++;
         end
         tick();
      end
      chk("t4_accept_count", 32'(n), 8);
      for (int j = 0; j < 8; j++)
         chk($sformatf("t4_stream[%0d]", j), acc[j], fib8[j]);

      // Asynchronous reset mid-run
      en = 1'b1; out_ready = 1'b1; start = 1'b1;
      tick();
      start = 1'b0;
      tick();
      tick();
      chk("t5_pre_valid", 32'(v[1]),  1);
      chk("t5_pre_index", 32'(ix[1]), 1);
      #2;
      reset = 1'b0;
      #1;
      chk("t5_rst_valid", 32'(v[1]),  0);
      chk("t5_rst_data",  32'(d[1]),  0);
      chk("t5_rst_index", 32'(ix[1]), 0);
      chk("t5_rst_busy",  32'(bz[1]), 0);
      chk("t5_rst_ovf0",  32'(ovf[0]), 0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
